// File: rtl/bitmap_alloc_256_pkg.sv
// Shared constants and state encoding for the 256-entry bitmap allocator.
package bitmap_alloc_256_pkg;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int CW    = 9;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SCAN = 2'd2
  } state_e;
endpackage

// File: rtl/bitmap_alloc_256_ram.sv
// Behavioural RAM256X1D: one write/read port (A/SPO), one async read port (DPRA/DPO).
// Power-up contents are not relied on; the controller clears every entry after reset.
module bitmap_alloc_256_ram
  import bitmap_alloc_256_pkg::*;
#(
  parameter bit IS_WCLK_INVERTED = 1'b0
) (
  input  logic          WCLK,
  input  logic          WE,
  input  logic          D,
  input  logic [AW-1:0] A,
  input  logic [AW-1:0] DPRA,
  output logic          SPO,
  output logic          DPO
);
  logic             wclk_i;
  logic [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0] mem_d;

  assign wclk_i = WCLK ^ IS_WCLK_INVERTED;

  always_comb begin
    mem_d = mem_q;
    if (WE) mem_d[A] = D;
  end

  always_ff @(posedge wclk_i) mem_q <= mem_d;

  assign SPO = mem_q[A];
  assign DPO = mem_q[DPRA];
endmodule

// File: rtl/bitmap_alloc_256.sv
// Bitmap allocation controller: post-reset clear sweep, next-fit allocate, checked free.
module bitmap_alloc_256
  import bitmap_alloc_256_pkg::*;
#(
  parameter bit NEXT_FIT = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ALLOC_REQ,
  output logic          ALLOC_ACK,
  output logic          ALLOC_FAIL,
  output logic [AW-1:0] ALLOC_IDX,
  input  logic          FREE_REQ,
  input  logic [AW-1:0] FREE_IDX,
  output logic          FREE_ACK,
  output logic          FREE_ERR,
  input  logic [AW-1:0] QUERY_IDX,
  output logic          QUERY_BIT,
  output logic [CW-1:0] FREE_CNT,
  output logic          INIT_DONE,
  output logic          BUSY
);
  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] hint_q, hint_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          alloc_ack_q, alloc_ack_d;
  logic          alloc_fail_q, alloc_fail_d;
  logic          free_ack_q, free_ack_d;
  logic          free_err_q, free_err_d;
  logic          init_done_q, init_done_d;

  logic          idle_accept, take_free, take_alloc;
  logic          ram_we, ram_d, ram_spo;
  logic [AW-1:0] ram_a;

  // A request still high during its own ACK cycle must not be taken again.
  assign idle_accept = (state_q == ST_IDLE) && !alloc_ack_q && !free_ack_q;
  assign take_free   = idle_accept && FREE_REQ;
  assign take_alloc  = idle_accept && !FREE_REQ && ALLOC_REQ;
  assign ram_a       = take_free ? FREE_IDX : ptr_q;

  bitmap_alloc_256_ram #(.IS_WCLK_INVERTED(1'b0)) u_ram (
    .WCLK (CLK),
    .WE   (ram_we),
    .D    (ram_d),
    .A    (ram_a),
    .DPRA (QUERY_IDX),
    .SPO  (ram_spo),
    .DPO  (QUERY_BIT)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (ptr_q == {AW{1'b1}}) state_d = ST_IDLE;
      ST_IDLE: if (take_alloc && cnt_q != '0) state_d = ST_SCAN;
      ST_SCAN: if (!ram_spo) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    ptr_d        = ptr_q;
    hint_d       = hint_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    init_done_d  = init_done_q;
    alloc_ack_d  = 1'b0;
    alloc_fail_d = 1'b0;
    free_ack_d   = 1'b0;
    free_err_d   = 1'b0;
    ram_we       = 1'b0;
    ram_d        = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        ram_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == {AW{1'b1}}) init_done_d = 1'b1;
      end
      ST_IDLE: begin
        if (take_free) begin
          free_ack_d = 1'b1;
          // Only a real 1->0 flip touches the RAM and the count.
          if (ram_spo) begin
            ram_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end else begin
            free_err_d = 1'b1;
          end
        end else if (take_alloc) begin
          if (cnt_q == '0) begin
            alloc_ack_d  = 1'b1;
            alloc_fail_d = 1'b1;
          end else begin
            ptr_d = NEXT_FIT ? hint_q : '0;
          end
        end
      end
      ST_SCAN: begin
        if (!ram_spo) begin
          ram_we      = 1'b1;
          ram_d       = 1'b1;
          cnt_d       = cnt_q - 1'b1;
          idx_d       = ptr_q;
          hint_d      = ptr_q + 1'b1;
          alloc_ack_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q        <= '0;
      hint_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= CW'(DEPTH);
      init_done_q  <= 1'b0;
      alloc_ack_q  <= 1'b0;
      alloc_fail_q <= 1'b0;
      free_ack_q   <= 1'b0;
      free_err_q   <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      hint_q       <= hint_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      init_done_q  <= init_done_d;
      alloc_ack_q  <= alloc_ack_d;
      alloc_fail_q <= alloc_fail_d;
      free_ack_q   <= free_ack_d;
      free_err_q   <= free_err_d;
    end
  end

  assign ALLOC_ACK  = alloc_ack_q;
  assign ALLOC_FAIL = alloc_fail_q;
  assign ALLOC_IDX  = idx_q;
  assign FREE_ACK   = free_ack_q;
  assign FREE_ERR   = free_err_q;
  assign FREE_CNT   = cnt_q;
  assign INIT_DONE  = init_done_q;
  assign BUSY       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_bitmap_alloc_256.sv
// Bench for bitmap_alloc_256: directed scenarios plus random alloc/free traffic vs a set-level model.
module tb_bitmap_alloc_256;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ALLOC_REQ = 1'b0;
  logic       FREE_REQ = 1'b0;
  logic [7:0] FREE_IDX = '0;
  logic [7:0] QUERY_IDX = '0;
  logic       ALLOC_ACK, ALLOC_FAIL, FREE_ACK, FREE_ERR, QUERY_BIT, INIT_DONE, BUSY;
  logic [7:0] ALLOC_IDX;
  logic [8:0] FREE_CNT;

  bitmap_alloc_256 #(.NEXT_FIT(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .ALLOC_REQ(ALLOC_REQ), .ALLOC_ACK(ALLOC_ACK), .ALLOC_FAIL(ALLOC_FAIL), .ALLOC_IDX(ALLOC_IDX),
    .FREE_REQ(FREE_REQ), .FREE_IDX(FREE_IDX), .FREE_ACK(FREE_ACK), .FREE_ERR(FREE_ERR),
    .QUERY_IDX(QUERY_IDX), .QUERY_BIT(QUERY_BIT), .FREE_CNT(FREE_CNT),
    .INIT_DONE(INIT_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  bit qrand  = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: no acknowledge within cycle budget at %0t", name, $time);
  endtask

  // Model: the set of used entries, the free count, and the next-fit hint.
  bit m_used [256];
  int m_cnt  = 256;
  int m_hint = 0;
  int m_idx  = 0;
  bit m_live = 1'b0;
  int m_exp;

  function automatic void m_reset();
    foreach (m_used[i]) m_used[i] = 1'b0;
    m_cnt  = 256;
    m_hint = 0;
    m_idx  = 0;
  endfunction

  function automatic int m_find();
    for (int d = 0; d < 256; d++)
      if (!m_used[(m_hint + d) % 256]) return (m_hint + d) % 256;
    return -1;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    if (m_live) begin
      if (ALLOC_ACK) begin
        chk("alloc_ack_unrequested", int'(ALLOC_REQ), 1);
        if (m_cnt == 0) begin
          chk("alloc_fail", int'(ALLOC_FAIL), 1);
        end else begin
          m_exp = m_find();
          chk("alloc_fail", int'(ALLOC_FAIL), 0);
          m_used[m_exp] = 1'b1;
          m_cnt--;
          m_hint = (m_exp + 1) % 256;
          m_idx  = m_exp;
        end
      end else begin
        chk("alloc_fail_idle", int'(ALLOC_FAIL), 0);
      end
      if (FREE_ACK) begin
        chk("free_ack_unrequested", int'(FREE_REQ), 1);
        chk("free_err", int'(FREE_ERR), m_used[FREE_IDX] ? 0 : 1);
        if (m_used[FREE_IDX]) begin
          m_used[FREE_IDX] = 1'b0;
          m_cnt++;
        end
      end else begin
        chk("free_err_idle", int'(FREE_ERR), 0);
      end
      chk("free_cnt", int'(FREE_CNT), m_cnt);
      chk("alloc_idx", int'(ALLOC_IDX), m_idx);
      if (INIT_DONE) chk("query_bit", int'(QUERY_BIT), int'(m_used[QUERY_IDX]));
    end
    if (RST) begin
      m_reset();
      m_live = 1'b1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (qrand) QUERY_IDX = 8'($urandom_range(0, 255));
  endtask

  // Each task raises its request, counts clock edges to the ACK, then drops it.
  task automatic do_alloc(output int lat, output int fail, output int idx);
    ALLOC_REQ = 1'b1;
    lat = 0; fail = 0; idx = 0;
    forever begin
      tick();
      lat++;
      @(negedge CLK);
      if (ALLOC_ACK) begin
        fail = int'(ALLOC_FAIL);
        idx  = int'(ALLOC_IDX);
        break;
      end
      if (lat > 600) begin
        timeout("alloc_wait");
        break;
      end
    end
    tick();
    ALLOC_REQ = 1'b0;
  endtask

  task automatic do_free(input int fidx, output int lat, output int err);
    FREE_IDX = 8'(fidx);
    FREE_REQ = 1'b1;
    lat = 0; err = 0;
    forever begin
      tick();
      lat++;
      @(negedge CLK);
      if (FREE_ACK) begin
        err = int'(FREE_ERR);
        break;
      end
      if (lat > 600) begin
        timeout("free_wait");
        break;
      end
    end
    tick();
    FREE_REQ = 1'b0;
  endtask

  task automatic reset_and_sweep();
    int n;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n = 0;
    forever begin
      @(negedge CLK);
      if (INIT_DONE) break;
      if (n == 0 || n == 255) chk("sweep_busy", int'(BUSY), 1);
      tick();
      n++;
      if (n > 400) begin
        timeout("sweep");
        break;
      end
    end
    chk("sweep_len", n, 256);
    chk("sweep_done_busy", int'(BUSY), 0);
    chk("sweep_cnt", int'(FREE_CNT), 256);
    tick();
  endtask

  task automatic query_all_clear(input string name);
    for (int i = 0; i < 256; i++) begin
      QUERY_IDX = 8'(i);
      @(negedge CLK);
      chk(name, int'(QUERY_BIT), 0);
      tick();
    end
  endtask

  initial begin
    #9_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int lat, fail, idx, err, lat2, r, h;
    repeat (3) tick();
    @(negedge CLK);
    chk("reset_busy", int'(BUSY), 1);
    chk("reset_init_done", int'(INIT_DONE), 0);
    chk("reset_cnt", int'(FREE_CNT), 256);
    chk("reset_ack", int'(ALLOC_ACK) + int'(FREE_ACK), 0);
    tick();
    reset_and_sweep();
    query_all_clear("init_query");

    for (int i = 0; i < 256; i++) begin
      do_alloc(lat, fail, idx);
      chk("seq_alloc_idx", idx, i);
      chk("seq_alloc_lat", lat, 2);
      chk("seq_alloc_fail", fail, 0);
    end
    chk("full_cnt", int'(FREE_CNT), 0);
    do_alloc(lat, fail, idx);
    chk("full_fail", fail, 1);
    chk("full_fail_lat", lat, 1);
    chk("full_idx_hold", idx, 255);

    do_free(17, lat, err);
    chk("free17_err", err, 0);
    chk("free17_lat", lat, 1);
    do_alloc(lat, fail, idx);
    chk("wrap_idx", idx, 17);
    chk("wrap_lat", lat, 19);

    do_free(5, lat, err);
    chk("free5_err", err, 0);
    chk("free5_cnt", int'(FREE_CNT), 1);
    do_free(5, lat, err);
    chk("free5_dup_err", err, 1);
    chk("free5_dup_cnt", int'(FREE_CNT), 1);
    QUERY_IDX = 8'd5;
    @(negedge CLK);
    chk("free5_query", int'(QUERY_BIT), 0);
    tick();

    fork
      do_free(200, lat, err);
      do_alloc(lat2, fail, idx);
    join
    chk("conc_free_lat", lat, 1);
    chk("conc_free_err", err, 0);
    chk("conc_alloc_lat", lat2, 186);
    chk("conc_alloc_idx", idx, 200);

    qrand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        do_alloc(lat, fail, idx);
      end else if (r < 8) begin
        do_free($urandom_range(0, 255), lat, err);
      end else begin
        fork
          do_free($urandom_range(0, 255), lat, err);
          do_alloc(lat2, fail, idx);
        join
      end
    end
    qrand = 1'b0;

    // Fill up, free the entry 99 past the hint, and reset mid-way through the scan.
    while (m_cnt > 0) do_alloc(lat, fail, idx);
    h = m_hint;
    do_free((h + 99) % 256, lat, err);
    chk("pre_scan_cnt", int'(FREE_CNT), 1);
    ALLOC_REQ = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      @(negedge CLK);
      chk("midscan_no_ack", int'(ALLOC_ACK), 0);
    end
    ALLOC_REQ = 1'b0;
    reset_and_sweep();
    query_all_clear("post_reset_query");
    chk("post_reset_cnt", int'(FREE_CNT), 256);
    do_alloc(lat, fail, idx);
    chk("post_reset_alloc_idx", idx, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
